pio_in_capture: RTL and testbench

- Parametrised Avalon-MM slave input port; next generation of the fixed 12-bit read-only PIO input.
- Adds a configurable width, a multi-stage input synchroniser, per-bit edge capture, an interrupt mask register and an irq output.
- Sits between board-level inputs (switches, keys, status lines) and the Nios/Avalon interconnect.
- Register map: 0 data (RO), 1 reserved (reads 0), 2 irq_mask (RW), 3 edge_capture (RO, write-1-to-clear).

---
 rtl/pio_pkg.sv | 19 +
 rtl/pio_sync_edge.sv | 60 ++++++
 rtl/pio_in_capture.sv | 108 ++++++++++
 tb/tb_pio_in_capture.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared constants for the parametrised PIO input capture port.
package pio_pkg;

    // Avalon word addresses of the register map
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // Capture edge selection, applied to every input bit
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Interrupt source selection
    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_sync_edge.sv
// Multi-stage input synchroniser followed by per-bit edge detection.
// Synchroniser and prev flops reset to 0, so an input held high through
// reset shows up as a rising event once it reaches data_sync.
module pio_sync_edge
    import pio_pkg::*;
#(
    parameter int WIDTH       = 12,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] data_sync,
    output logic [WIDTH-1:0] ev
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    // Shift the asynchronous inputs through the synchroniser chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign data_sync = sync_q[SYNC_STAGES-1];

    // Remember last cycle's synchronised value for edge comparison
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else begin
            prev <= data_sync;
        end
    end

    // Select the event type from the rise/fall terms
    always_comb begin
        rise = data_sync & ~prev;
        fall = ~data_sync & prev;
        ev   = rise;
        if (EDGE_TYPE == EDGE_FALL) begin
            ev = fall;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            ev = rise | fall;
        end
    end

endmodule

// File: rtl/pio_in_capture.sv
// Avalon-MM input port: synchronised data, edge capture with W1C,
// interrupt mask and a registered irq. Read data is registered every
// cycle from the current address, so a read returns the pre-write value.
module pio_in_capture
    import pio_pkg::*;
#(
    parameter int               WIDTH       = 12,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               IRQ_MODE    = IRQ_EDGE,
    parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] data_sync;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] clr_bits;
    logic             wr_en;
    logic             wr_mask;
    logic             wr_edge;
    logic             irq_src;
    logic [31:0]      rd_next;
    logic             unused_wdata;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_port   (in_port),
        .data_sync (data_sync),
        .ev        (ev)
    );

    // Upper writedata bits beyond WIDTH have no destination
    assign unused_wdata = ^writedata;

    assign wdata    = writedata[WIDTH-1:0];
    assign wr_en    = chipselect & ~write_n;
    assign wr_mask  = wr_en && (address == ADDR_MASK);
    assign wr_edge  = wr_en && (address == ADDR_EDGE);
    assign clr_bits = wr_edge ? wdata : '0;

    // Interrupt mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= RESET_MASK;
        end else if (wr_mask) begin
            irq_mask <= wdata;
        end
    end

    // Edge capture: write-1-to-clear, a new event in the same cycle wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~clr_bits) | ev;
        end
    end

    // Read mux, zero-extending WIDTH-bit registers to the bus width
    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA: rd_next[WIDTH-1:0] = data_sync;
            ADDR_MASK: rd_next[WIDTH-1:0] = irq_mask;
            ADDR_EDGE: rd_next[WIDTH-1:0] = edge_capture;
            default:   rd_next = '0;
        endcase
    end

    // Registered read data, one cycle latency, independent of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

    assign irq_src = (IRQ_MODE == IRQ_EDGE) ? |(edge_capture & irq_mask)
                                            : |(data_sync & irq_mask);

    // Registered interrupt request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_src;
        end
    end

endmodule

// File: tb/tb_pio_in_capture.sv
// Directed bench for pio_in_capture: a default build (rising edge, edge irq)
// and a second build (any edge, level irq) sharing the Avalon bus.
module tb_pio_in_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        reset_n2;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [11:0] in_port;
    logic [11:0] in_port2;
    logic [31:0] readdata;
    logic [31:0] readdata2;
    logic        irq;
    logic        irq2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_in_capture u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    pio_in_capture #(
        .EDGE_TYPE (2),
        .IRQ_MODE  (0)
    ) u_dut2 (
        .clk        (clk),
        .reset_n    (reset_n2),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata2),
        .in_port    (in_port2),
        .irq        (irq2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        reset_n2   = 1'b0;
        in_port    = '0;
        in_port2   = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
        #1;
        checks++;
        if (readdata !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: readdata=%h irq=%b expected 0/0", readdata, irq);
        end
        repeat (2) step();
        reset_n  = 1'b1;
        reset_n2 = 1'b1;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            step();
            checks++;
            if (readdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_read addr %0d: got %h expected 00000000", a, readdata);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
        // writes to data and reserved addresses have no effect
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_write(2'd1, 32'hFFFF_FFFF);
        address = 2'd2;
        step();
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL ignored_write_mask: got %h expected 00000000", readdata);
        end
        address = 2'd1;
        step();
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL rsvd_read: got %h expected 00000000", readdata);
        end
    endtask

    task automatic test_sync_latency();
        address = 2'd0;
        step();
        in_port = 12'hA5C;
        step();
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL sync_lat_e1: got %h expected 00000000", readdata);
        end
        step();
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL sync_lat_e2: got %h expected 00000000", readdata);
        end
        step();
        checks++;
        if (readdata !== 32'h0000_0A5C) begin
            errors++;
            $display("FAIL sync_lat_e3: got %h expected 00000a5c", readdata);
        end
        step();
        checks++;
        if (readdata !== 32'h0000_0A5C || irq !== 1'b0) begin
            errors++;
            $display("FAIL sync_hold: got %h irq=%b expected 00000a5c irq=0", readdata, irq);
        end
        in_port = '0;
        repeat (4) step();
        bus_write(2'd3, 32'h0000_0FFF);
        address = 2'd3;
        step();
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL edge_w1c_all: got %h expected 00000000", readdata);
        end
    endtask

    task automatic test_rise_irq();
        bus_write(2'd2, 32'hFFFF_F001);
        address = 2'd2;
        step();
        checks++;
        if (readdata !== 32'h0000_0001) begin
            errors++;
            $display("FAIL mask_readback: got %h expected 00000001", readdata);
        end
        address = 2'd3;
        step();
        in_port = 12'h001;
        step();
        step();
        step();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_early: got %b expected 0", irq);
        end
        step();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_at_4: got %b expected 1", irq);
        end
        checks++;
        if (readdata !== 32'h0000_0001) begin
            errors++;
            $display("FAIL rise_capture: got %h expected 00000001", readdata);
        end
        bus_write(2'd3, 32'h0000_0001);
        checks++;
        if (readdata !== 32'h0000_0001 || irq !== 1'b1) begin
            errors++;
            $display("FAIL read_before_clear: got %h irq=%b expected 00000001 irq=1", readdata, irq);
        end
        step();
        checks++;
        if (readdata !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL clear_irq: got %h irq=%b expected 00000000 irq=0", readdata, irq);
        end
    endtask

    task automatic test_masked_edge();
        address = 2'd3;
        in_port = 12'h021;
        repeat (4) step();
        checks++;
        if (readdata !== 32'h0000_0020) begin
            errors++;
            $display("FAIL masked_capture: got %h expected 00000020", readdata);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL masked_irq: got %b expected 0", irq);
        end
        bus_write(2'd2, 32'h0000_0020);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_write_same: got %b expected 0", irq);
        end
        step();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL mask_write_irq: got %b expected 1", irq);
        end
    endtask

    task automatic test_set_beats_clear();
        in_port = '0;
        repeat (4) step();
        bus_write(2'd3, 32'h0000_0FFF);
        in_port = 12'h021;
        repeat (4) step();
        address = 2'd3;
        step();
        checks++;
        if (readdata !== 32'h0000_0021) begin
            errors++;
            $display("FAIL pre_set: got %h expected 00000021", readdata);
        end
        in_port = 12'h029;
        step();
        step();
        bus_write(2'd3, 32'h0000_0FFF);
        step();
        checks++;
        if (readdata !== 32'h0000_0008) begin
            errors++;
            $display("FAIL set_beats_clear: got %h expected 00000008", readdata);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL set_clear_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_any_level();
        bus_write(2'd2, 32'h0000_0001);
        address  = 2'd0;
        in_port2 = 12'h001;
        step();
        step();
        checks++;
        if (irq2 !== 1'b0) begin
            errors++;
            $display("FAIL lvl_irq_early: got %b expected 0", irq2);
        end
        step();
        checks++;
        if (irq2 !== 1'b1 || readdata2 !== 32'h0000_0001) begin
            errors++;
            $display("FAIL lvl_irq_rise: irq=%b rd=%h expected 1/00000001", irq2, readdata2);
        end
        repeat (2) step();
        bus_write(2'd3, 32'h0000_0FFF);
        in_port2 = '0;
        step();
        step();
        checks++;
        if (irq2 !== 1'b1) begin
            errors++;
            $display("FAIL lvl_irq_hold: got %b expected 1", irq2);
        end
        step();
        checks++;
        if (irq2 !== 1'b0) begin
            errors++;
            $display("FAIL lvl_irq_fall: got %b expected 0", irq2);
        end
        address = 2'd3;
        step();
        checks++;
        if (readdata2 !== 32'h0000_0001) begin
            errors++;
            $display("FAIL any_fall_capture: got %h expected 00000001", readdata2);
        end
        in_port2 = 12'h001;
        address  = 2'd0;
        repeat (3) step();
        checks++;
        if (irq2 !== 1'b1) begin
            errors++;
            $display("FAIL lvl_irq_pulse: got %b expected 1", irq2);
        end
        reset_n2 = 1'b0;
        #1;
        checks++;
        if (irq2 !== 1'b0 || readdata2 !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: irq=%b rd=%h expected 0/00000000", irq2, readdata2);
        end
        step();
        reset_n2 = 1'b1;
        address  = 2'd3;
        repeat (4) step();
        checks++;
        if (readdata2 !== 32'h0000_0001) begin
            errors++;
            $display("FAIL post_reset_rise: got %h expected 00000001", readdata2);
        end
        checks++;
        if (irq2 !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_mask: got %b expected 0", irq2);
        end
    endtask

    initial begin
        test_reset();
        test_sync_latency();
        test_rise_irq();
        test_masked_edge();
        test_set_beats_clear();
        test_any_level();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
